// File: rtl/uart_pwm_pkg.sv
// Shared types and constants for the UART command parser that drives the PWM configuration.
// Holds the parser state encoding, the ASCII vocabulary and the acknowledgement byte lookup.
package uart_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NUM,
        DISCARD,
        RESP
    } parser_state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_F_LC = 8'h66;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_R    = 8'h52;

    localparam int unsigned MAX_DUTY_PCT = 100;

    // Byte idx of the four-byte acknowledgement: "OK\r\n" when ok, else "ER\r\n".
    function automatic logic [7:0] resp_byte(input logic ok, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ok ? ASCII_O : ASCII_E;
            2'd1:    b = ok ? ASCII_K : ASCII_R;
            2'd2:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cmd_dec_accum.sv
// Decimal accumulator for the command parser: acc = acc*10 + digit with a digit counter.
// 'overflow' is high when one more digit would take the count past MAX_DIGITS.
module cmd_dec_accum #(
    parameter int MAX_DIGITS = 7,
    parameter int ACC_W      = 24
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc,
    output logic             has_digits,
    output logic             overflow
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (step && !overflow) begin
            acc   <= acc * ACC_W'(10) + ACC_W'(digit);
            count <= count + CNT_W'(1);
        end
    end

    assign has_digits = (count != '0);
    assign overflow   = (count >= CNT_W'(MAX_DIGITS));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes "<F|D><digits><CR|LF>" commands from the UART receiver into PWM frequency/duty
// registers and streams an "OK\r\n" / "ER\r\n" acknowledgement over a valid/ready handshake.
module uart_cmd_parser
    import uart_pwm_pkg::*;
#(
    parameter int unsigned DEFAULT_FREQ_HZ  = 1000,
    parameter int unsigned DEFAULT_DUTY_PCT = 50,
    parameter int unsigned MAX_FREQ_HZ      = 1_000_000,
    parameter int          MAX_DIGITS       = 7
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [19:0] freq_hz,
    output logic [6:0]  duty_pct,
    output logic        cfg_update,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    input  logic        resp_ready
);

    localparam int ACC_W = 24;
    localparam logic [ACC_W-1:0] MAX_FREQ_ACC = 24'(MAX_FREQ_HZ);
    localparam logic [ACC_W-1:0] MAX_DUTY_ACC = 24'(MAX_DUTY_PCT);

    parser_state_e    state;
    logic             cmd_freq;
    logic             err;
    logic [1:0]       idx;

    logic [ACC_W-1:0] acc;
    logic             has_digits;
    logic             acc_full;
    logic             acc_clear;
    logic             acc_step;

    logic             is_term;
    logic             is_digit;
    logic             is_f;
    logic             is_d;
    logic             eval_ok;

    always_comb begin
        is_term   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
        is_digit  = (rx_data >= ASCII_ZERO) && (rx_data <= (ASCII_ZERO + 8'd9));
        is_f      = (rx_data == ASCII_F) || (rx_data == ASCII_F_LC);
        is_d      = (rx_data == ASCII_D) || (rx_data == ASCII_D_LC);
        acc_clear = rx_valid && (state == IDLE) && (is_f || is_d);
        acc_step  = rx_valid && (state == NUM) && is_digit && !acc_full;
        // Range checks see the full 24-bit accumulator so large values cannot alias into range.
        if (!has_digits) begin
            eval_ok = 1'b0;
        end else if (cmd_freq) begin
            eval_ok = (acc != '0) && (acc <= MAX_FREQ_ACC);
        end else begin
            eval_ok = (acc <= MAX_DUTY_ACC);
        end
    end

    cmd_dec_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .ACC_W      (ACC_W)
    ) u_accum (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .clear      (acc_clear),
        .step       (acc_step),
        .digit      (rx_data[3:0]),
        .acc        (acc),
        .has_digits (has_digits),
        .overflow   (acc_full)
    );

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_freq   <= 1'b0;
            err        <= 1'b0;
            idx        <= 2'd0;
            freq_hz    <= 20'(DEFAULT_FREQ_HZ);
            duty_pct   <= 7'(DEFAULT_DUTY_PCT);
            cfg_update <= 1'b0;
            resp_data  <= 8'h00;
            resp_valid <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            case (state)
                IDLE: begin
                    // A lone terminator here is the LF of a CRLF pair and is swallowed silently.
                    if (rx_valid) begin
                        if (is_f || is_d) begin
                            cmd_freq <= is_f;
                            state    <= NUM;
                        end else if (!is_term) begin
                            err   <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                end
                NUM: begin
                    if (rx_valid) begin
                        if (is_digit) begin
                            if (acc_full) begin
                                err   <= 1'b1;
                                state <= DISCARD;
                            end
                        end else if (is_term) begin
                            if (eval_ok) begin
                                if (cmd_freq) begin
                                    freq_hz <= acc[19:0];
                                end else begin
                                    duty_pct <= acc[6:0];
                                end
                                cfg_update <= 1'b1;
                            end
                            err        <= !eval_ok;
                            idx        <= 2'd0;
                            resp_data  <= resp_byte(eval_ok, 2'd0);
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            err   <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_valid && is_term) begin
                        err        <= 1'b1;
                        idx        <= 2'd0;
                        resp_data  <= resp_byte(1'b0, 2'd0);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Incoming bytes are ignored here; resp_data only moves on an accepted transfer.
                    if (resp_ready) begin
                        if (idx == 2'd3) begin
                            resp_valid <= 1'b0;
                            resp_data  <= 8'h00;
                            idx        <= 2'd0;
                            err        <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx       <= idx + 2'd1;
                            resp_data <= resp_byte(!err, idx + 2'd1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed command scenarios plus randomized
// command strings checked against a string-level model of the command grammar.
module tb_uart_cmd_parser;

    localparam logic [7:0]  CR      = 8'h0D;
    localparam logic [7:0]  LF      = 8'h0A;
    localparam logic [31:0] RESP_OK = 32'h4F4B0D0A;
    localparam logic [31:0] RESP_ER = 32'h45520D0A;

    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [19:0] freq_hz;
    logic [6:0]  duty_pct;
    logic        cfg_update;
    logic [7:0]  resp_data;
    logic        resp_valid;
    logic        resp_ready;

    logic        ready_cmd = 1'b1;
    logic        rand_ready = 1'b0;
    logic        rand_bit = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int          cfg_count = 0;
    int          cycle = 0;
    int          model_freq = 1000;
    int          model_duty = 50;
    byte unsigned resp_q[$];
    int          resp_cyc[$];
    logic        stall_pending = 1'b0;
    logic [7:0]  held_data = 8'h00;

    assign resp_ready = rand_ready ? rand_bit : ready_cmd;

    uart_cmd_parser dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .freq_hz    (freq_hz),
        .duty_pct   (duty_pct),
        .cfg_update (cfg_update),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        rand_bit = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Transfer log, cfg_update pulse counter and hold-while-stalled check.
    always @(posedge clk_50mhz) begin
        cycle <= cycle + 1;
        if (cfg_update) cfg_count <= cfg_count + 1;
        if (resp_valid && resp_ready) begin
            resp_q.push_back(resp_data);
            resp_cyc.push_back(cycle);
        end
        if (stall_pending && rst_n) checkOutput("hold_stable", {23'd0, resp_valid, resp_data}, {23'd0, 1'b1, held_data});
        stall_pending <= resp_valid && !resp_ready;
        held_data     <= resp_data;
    end

    // Reference: decides the outcome of one command line purely from the grammar rules.
    function automatic bit modelCommand(input string cmd, input int freq_in, input int duty_in,
                                        output int freq_out, output int duty_out);
        longint val;
        byte unsigned c;
        bit is_freq;
        freq_out = freq_in;
        duty_out = duty_in;
        val = 0;
        if (cmd.len() == 0) return 1'b0;
        c = cmd[0];
        if (c == 8'h46 || c == 8'h66) is_freq = 1'b1;
        else if (c == 8'h44 || c == 8'h64) is_freq = 1'b0;
        else return 1'b0;
        if (cmd.len() - 1 == 0 || cmd.len() - 1 > 7) return 1'b0;
        for (int i = 1; i < cmd.len(); i++) begin
            c = cmd[i];
            if (c < 8'h30 || c > 8'h39) return 1'b0;
            val = val * 10 + longint'(c - 8'h30);
        end
        if (is_freq) begin
            if (val == 0 || val > 1000000) return 1'b0;
            freq_out = int'(val);
        end else begin
            if (val > 100) return 1'b0;
            duty_out = int'(val);
        end
        return 1'b1;
    endfunction

    function automatic string randomCommand();
        byte unsigned letters[7] = '{8'h46, 8'h66, 8'h44, 8'h64, 8'h58, 8'h71, 8'h35};
        byte unsigned junk[4] = '{8'h58, 8'h2E, 8'h20, 8'h2D};
        string s;
        string t;
        longint v;
        int kind;
        int pos;
        s = $sformatf("%c", letters[$urandom_range(0, 6)]);
        kind = $urandom_range(0, 5);
        case (kind)
            0:       v = $urandom_range(0, 120);
            1:       v = $urandom_range(1, 1000000);
            2:       v = 1000000 + $urandom_range(0, 2);
            3:       v = $urandom_range(0, 9999999);
            4:       v = 10000000 + $urandom_range(0, 89999999);
            default: v = -1;
        endcase
        if (v >= 0) begin
            if ($urandom_range(0, 5) == 0) s = {s, "0"};
            s = {s, $sformatf("%0d", v)};
        end
        if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(0, s.len());
            t = "";
            for (int i = 0; i < s.len(); i++) begin
                if (i == pos) t = {t, $sformatf("%c", junk[$urandom_range(0, 3)])};
                t = {t, $sformatf("%c", s[i])};
            end
            if (pos == s.len()) t = {t, $sformatf("%c", junk[$urandom_range(0, 3)])};
            s = t;
        end
        return s;
    endfunction

    function automatic logic [31:0] respWord();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = {w[23:0], (i < resp_q.size()) ? resp_q[i] : 8'h00};
        return w;
    endfunction

    task automatic sendByte(input byte unsigned b);
        @(negedge clk_50mhz);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_50mhz);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic applyStimulus(input string cmd, input byte unsigned term);
        for (int i = 0; i < cmd.len(); i++) sendByte(cmd[i]);
        if (term != 8'h00) sendByte(term);
    endtask

    task automatic waitResponse();
        int n;
        n = 0;
        while ((resp_q.size() < 4 || resp_valid) && n < 200) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (n >= 200) checkOutput("resp_timeout", 32'(resp_q.size()), 32'd4);
    endtask

    task automatic applyReset();
        @(negedge clk_50mhz);
        rst_n = 1'b0;
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        model_freq = 1000;
        model_duty = 50;
        resp_q.delete();
        resp_cyc.delete();
    endtask

    // lf_mode: 0 none, 1 LF right after the terminator (lands in RESP), 2 LF after the response.
    task automatic runCommand(input string tag, input string cmd, input byte unsigned term, input int lf_mode);
        int base;
        int nf;
        int nd;
        bit ok;
        base = cfg_count;
        resp_q.delete();
        resp_cyc.delete();
        applyStimulus(cmd, term);
        if (lf_mode == 1) sendByte(LF);
        waitResponse();
        if (lf_mode == 2) sendByte(LF);
        repeat (6) @(negedge clk_50mhz);
        ok = modelCommand(cmd, model_freq, model_duty, nf, nd);
        checkOutput({tag, "_resp"}, respWord(), ok ? RESP_OK : RESP_ER);
        checkOutput({tag, "_nbytes"}, 32'(resp_q.size()), 32'd4);
        checkOutput({tag, "_freq"}, 32'(freq_hz), 32'(nf));
        checkOutput({tag, "_duty"}, 32'(duty_pct), 32'(nd));
        checkOutput({tag, "_cfg"}, 32'(cfg_count - base), ok ? 32'd1 : 32'd0);
        model_freq = nf;
        model_duty = nd;
    endtask

    initial begin
        int base;
        int n;
        string cmd;

        repeat (3) @(negedge clk_50mhz);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        checkOutput("reset_freq", 32'(freq_hz), 32'd1000);
        checkOutput("reset_duty", 32'(duty_pct), 32'd50);
        checkOutput("reset_cfg", 32'(cfg_update), 32'd0);
        checkOutput("reset_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_data", 32'(resp_data), 32'd0);

        $display("[TB] F2500 timing");
        base = cfg_count;
        resp_q.delete();
        resp_cyc.delete();
        applyStimulus("F2500", CR);
        checkOutput("F2500_valid_n1", 32'(resp_valid), 32'd1);
        checkOutput("F2500_first_byte", 32'(resp_data), 32'h4F);
        checkOutput("F2500_cfg_n1", 32'(cfg_update), 32'd1);
        checkOutput("F2500_freq_n1", 32'(freq_hz), 32'd2500);
        @(negedge clk_50mhz);
        checkOutput("F2500_cfg_n2", 32'(cfg_update), 32'd0);
        waitResponse();
        checkOutput("F2500_resp", respWord(), RESP_OK);
        checkOutput("F2500_span", (resp_cyc.size() >= 4) ? 32'(resp_cyc[3] - resp_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
        checkOutput("F2500_cfg_count", 32'(cfg_count - base), 32'd1);
        model_freq = 2500;

        $display("[TB] CRLF handling");
        runCommand("d75_crlf", "d75", CR, 1);
        runCommand("lone_lf_absorbed", "d42", CR, 2);

        $display("[TB] rejected commands");
        applyReset();
        runCommand("D101", "D101", CR, 0);
        runCommand("F0", "F0", CR, 0);
        runCommand("F_empty", "F", CR, 0);
        runCommand("X12", "X12", CR, 0);
        checkOutput("err_freq_default", 32'(freq_hz), 32'd1000);
        checkOutput("err_duty_default", 32'(duty_pct), 32'd50);

        $display("[TB] digit limit and max frequency");
        runCommand("F8digits", "F12345678", CR, 0);
        runCommand("Fmax", "F1000000", LF, 0);

        $display("[TB] backpressure");
        ready_cmd = 1'b0;
        base = cfg_count;
        resp_q.delete();
        resp_cyc.delete();
        applyStimulus("D10", CR);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 32'(resp_valid), 32'd1);
            checkOutput("stall_data", 32'(resp_data), 32'h4F);
            @(negedge clk_50mhz);
        end
        applyStimulus("D20", CR);
        checkOutput("stall_after_inject", 32'(resp_data), 32'h4F);
        checkOutput("stall_no_transfer", 32'(resp_q.size()), 32'd0);
        n = 0;
        while ((resp_q.size() < 4 || resp_valid) && n < 100) begin
            ready_cmd = ~ready_cmd;
            @(negedge clk_50mhz);
            n++;
        end
        ready_cmd = 1'b1;
        repeat (6) @(negedge clk_50mhz);
        checkOutput("stall_resp", respWord(), RESP_OK);
        checkOutput("stall_nbytes", 32'(resp_q.size()), 32'd4);
        checkOutput("stall_duty", 32'(duty_pct), 32'd10);
        checkOutput("stall_freq", 32'(freq_hz), 32'd1000000);
        checkOutput("stall_cfg", 32'(cfg_count - base), 32'd1);
        model_duty = 10;
        model_freq = 1000000;

        $display("[TB] reset mid-command and mid-response");
        applyStimulus("F3", 8'h00);
        #5 rst_n = 1'b0;
        #1;
        checkOutput("midcmd_freq", 32'(freq_hz), 32'd1000);
        checkOutput("midcmd_duty", 32'(duty_pct), 32'd50);
        checkOutput("midcmd_valid", 32'(resp_valid), 32'd0);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        model_freq = 1000;
        model_duty = 50;
        runCommand("D5_after_reset", "D5", CR, 0);
        resp_q.delete();
        applyStimulus("F77", CR);
        checkOutput("midresp_started", 32'(resp_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midresp_freq", 32'(freq_hz), 32'd1000);
        checkOutput("midresp_duty", 32'(duty_pct), 32'd50);
        checkOutput("midresp_valid", 32'(resp_valid), 32'd0);
        checkOutput("midresp_data", 32'(resp_data), 32'd0);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        model_freq = 1000;
        model_duty = 50;
        repeat (6) @(negedge clk_50mhz);
        checkOutput("midresp_no_bytes", 32'(resp_q.size()), 32'd0);

        $display("[TB] randomized commands");
        applyReset();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cmd = randomCommand();
            runCommand($sformatf("rnd%0d_%s", i, cmd), cmd, ($urandom_range(0, 1) != 0) ? CR : LF,
                       int'($urandom_range(0, 2)));
        end
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
